// File: rtl/branch_predictor_btb_if.sv
// Pipeline-to-BTB bundle: fetch-side lookup plus E-stage resolution signals.
// The pipeline drives through the master modport; the predictor uses the slave modport.
interface branch_predictor_btb_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_f;
    logic            pred_taken_f;
    logic [XLEN-1:0] pred_target_f;
    logic            valid_e;
    logic [XLEN-1:0] pc_e;
    logic            is_branch_e;
    logic            is_jal_e;
    logic            is_jalr_e;
    logic [2:0]      br_type_e;
    logic            eq_e;
    logic            lt_e;
    logic            ltu_e;
    logic [XLEN-1:0] imm_target_e;
    logic [XLEN-1:0] jalr_target_e;
    logic            pred_taken_e;
    logic [XLEN-1:0] pred_target_e;
    logic            mispredict_e;
    logic [XLEN-1:0] redirect_pc_e;

    modport master (
        output pc_f, valid_e, pc_e, is_branch_e, is_jal_e, is_jalr_e, br_type_e,
               eq_e, lt_e, ltu_e, imm_target_e, jalr_target_e, pred_taken_e, pred_target_e,
        input  pred_taken_f, pred_target_f, mispredict_e, redirect_pc_e
    );

    modport slave (
        input  pc_f, valid_e, pc_e, is_branch_e, is_jal_e, is_jalr_e, br_type_e,
               eq_e, lt_e, ltu_e, imm_target_e, jalr_target_e, pred_taken_e, pred_target_e,
        output pred_taken_f, pred_target_f, mispredict_e, redirect_pc_e
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating counters, same-cycle fetch lookup and E-stage training.
// Optional macro BPRED_STATS_EN adds resolved-control and mispredict counters (stat_ctl_o/stat_miss_o).
module branch_predictor_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef BPRED_STATS_EN
    output logic [31:0]          stat_ctl_o,
    output logic [31:0]          stat_miss_o,
`endif
    branch_predictor_btb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [XLEN-1:0]   r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];

    logic [IDX_W-1:0]  w_fIdx;
    logic [TAG_W-1:0]  w_fTag;
    logic              w_fHit;
    logic [IDX_W-1:0]  w_eIdx;
    logic [TAG_W-1:0]  w_eTag;
    logic              w_eHit;
    logic              w_cond;
    logic              w_taken;
    logic [XLEN-1:0]   w_actTgt;
    logic [XLEN-1:0]   w_pcE4;
    logic              w_wrEn;
    logic              w_wrValid;
    logic [XLEN-1:0]   w_wrTarget;
    logic [1:0]        w_wrCtr;
    logic              w_unusedPcBits;

    assign w_fIdx = bus.pc_f[IDX_W+1:2];
    assign w_fTag = bus.pc_f[IDX_W+2+TAG_W-1:IDX_W+2];
    assign w_eIdx = bus.pc_e[IDX_W+1:2];
    assign w_eTag = bus.pc_e[IDX_W+2+TAG_W-1:IDX_W+2];
    assign w_unusedPcBits = ^{bus.pc_f, bus.pc_e};

    // Fetch lookup reads the pre-edge table contents; there is no write bypass.
    assign w_fHit            = r_valid[w_fIdx] && (r_tag[w_fIdx] == w_fTag);
    assign bus.pred_taken_f  = w_fHit && r_ctr[w_fIdx][1];
    assign bus.pred_target_f = bus.pred_taken_f ? r_target[w_fIdx] : bus.pc_f + XLEN'(4);

    assign w_eHit = r_valid[w_eIdx] && (r_tag[w_eIdx] == w_eTag);
    assign w_pcE4 = bus.pc_e + XLEN'(4);

    always_comb begin
        w_cond = 1'b0;
        case (bus.br_type_e)
            3'b000:  w_cond = bus.eq_e;
            3'b001:  w_cond = !bus.eq_e;
            3'b100:  w_cond = bus.lt_e;
            3'b101:  w_cond = !bus.lt_e;
            3'b110:  w_cond = bus.ltu_e;
            3'b111:  w_cond = !bus.ltu_e;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken  = bus.is_jal_e || bus.is_jalr_e || (bus.is_branch_e && w_cond);
    assign w_actTgt = bus.is_jalr_e ? bus.jalr_target_e : bus.imm_target_e;

    always_comb begin
        bus.mispredict_e  = 1'b0;
        bus.redirect_pc_e = w_pcE4;
        if (bus.valid_e) begin
            bus.mispredict_e  = (w_taken != bus.pred_taken_e) ||
                                (w_taken && bus.pred_taken_e && (w_actTgt != bus.pred_target_e));
            bus.redirect_pc_e = w_taken ? w_actTgt : w_pcE4;
        end
    end

    // Jumps always install as strongly taken; a hit by a non-control instruction means an alias, so drop it.
    always_comb begin
        w_wrEn     = 1'b0;
        w_wrValid  = 1'b1;
        w_wrTarget = r_target[w_eIdx];
        w_wrCtr    = r_ctr[w_eIdx];
        if (bus.valid_e) begin
            if (bus.is_jal_e || bus.is_jalr_e) begin
                w_wrEn     = 1'b1;
                w_wrTarget = w_actTgt;
                w_wrCtr    = 2'b11;
            end else if (bus.is_branch_e) begin
                if (w_eHit) begin
                    w_wrEn = 1'b1;
                    if (w_taken) begin
                        w_wrTarget = w_actTgt;
                        w_wrCtr    = (r_ctr[w_eIdx] == 2'b11) ? 2'b11 : r_ctr[w_eIdx] + 2'b01;
                    end else begin
                        w_wrCtr    = (r_ctr[w_eIdx] == 2'b00) ? 2'b00 : r_ctr[w_eIdx] - 2'b01;
                    end
                end else if (w_taken) begin
                    w_wrEn     = 1'b1;
                    w_wrTarget = w_actTgt;
                    w_wrCtr    = 2'b10;
                end
            end else if (w_eHit) begin
                w_wrEn    = 1'b1;
                w_wrValid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_wrEn) begin
            r_valid[w_eIdx]  <= w_wrValid;
            r_tag[w_eIdx]    <= w_eTag;
            r_target[w_eIdx] <= w_wrTarget;
            r_ctr[w_eIdx]    <= w_wrCtr;
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] r_statCtl;
    logic [31:0] r_statMiss;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_statCtl  <= '0;
            r_statMiss <= '0;
        end else begin
            if (bus.valid_e && (bus.is_branch_e || bus.is_jal_e || bus.is_jalr_e))
                r_statCtl <= r_statCtl + 32'd1;
            if (bus.mispredict_e)
                r_statMiss <= r_statMiss + 32'd1;
        end
    end

    assign stat_ctl_o  = r_statCtl;
    assign stat_miss_o = r_statMiss;
`endif
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed plus randomized bench for branch_predictor_btb against a table-of-integers reference model.
// Define BPRED_STATS_EN for both bench and RTL to also check the statistics counters.
module tb_branch_predictor_btb;
    localparam int KIND_NONE = 0;
    localparam int KIND_BR   = 1;
    localparam int KIND_JAL  = 2;
    localparam int KIND_JALR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    int          mValid  [16];
    int          mTag    [16];
    logic [31:0] mTarget [16];
    int          mCtr    [16];
    int          mCtl  = 0;
    int          mMiss = 0;

    logic [31:0] pcPool  [8];
    logic [31:0] tgtPool [4];

    branch_predictor_btb_if #(.XLEN(32)) bus ();

`ifdef BPRED_STATS_EN
    logic [31:0] statCtl;
    logic [31:0] statMiss;
`endif

    branch_predictor_btb #(.XLEN(32), .ENTRIES(16), .TAG_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef BPRED_STATS_EN
        .stat_ctl_o  (statCtl),
        .stat_miss_o (statMiss),
`endif
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic int tagOf(input logic [31:0] pc);
        return int'((pc >> 6) % 256);
    endfunction

    function automatic int modelHit(input logic [31:0] pc);
        return (mValid[idxOf(pc)] != 0 && mTag[idxOf(pc)] == tagOf(pc)) ? 1 : 0;
    endfunction

    task automatic modelLookup(input logic [31:0] pc, output logic taken, output logic [31:0] tgt);
        taken = (modelHit(pc) != 0) && (mCtr[idxOf(pc)] >= 2);
        tgt   = taken ? mTarget[idxOf(pc)] : pc + 32'd4;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mValid[i]  = 0;
            mTag[i]    = 0;
            mTarget[i] = 32'h0;
            mCtr[i]    = 1;
        end
        mCtl  = 0;
        mMiss = 0;
    endtask

    // One cycle: drive E/F inputs, check combinational outputs against the model, clock, then train the model.
    task automatic applyStimulus(input string tag, input logic [31:0] pcF, input logic validE,
                                 input logic [31:0] pcE, input int kind, input logic [2:0] brType,
                                 input logic eq, input logic lt, input logic ltu,
                                 input logic [31:0] immT, input logic [31:0] jalrT,
                                 input logic predT, input logic [31:0] predTgt);
        logic        cond;
        logic        taken;
        logic [31:0] act;
        logic        expMiss;
        logic [31:0] expRedir;
        logic        expPredT;
        logic [31:0] expPredTgt;
        int          i;
        int          hit;

        bus.pc_f          = pcF;
        bus.valid_e       = validE;
        bus.pc_e          = pcE;
        bus.is_branch_e   = (kind == KIND_BR);
        bus.is_jal_e      = (kind == KIND_JAL);
        bus.is_jalr_e     = (kind == KIND_JALR);
        bus.br_type_e     = brType;
        bus.eq_e          = eq;
        bus.lt_e          = lt;
        bus.ltu_e         = ltu;
        bus.imm_target_e  = immT;
        bus.jalr_target_e = jalrT;
        bus.pred_taken_e  = predT;
        bus.pred_target_e = predTgt;
        #2;

        case (brType)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt;
            3'b101:  cond = !lt;
            3'b110:  cond = ltu;
            3'b111:  cond = !ltu;
            default: cond = 1'b0;
        endcase
        taken    = (kind == KIND_JAL) || (kind == KIND_JALR) || ((kind == KIND_BR) && cond);
        act      = (kind == KIND_JALR) ? jalrT : immT;
        expMiss  = validE && ((taken != predT) || (taken && predT && act != predTgt));
        expRedir = (validE && taken) ? act : pcE + 32'd4;
        modelLookup(pcF, expPredT, expPredTgt);

        checkOutput({tag, ".predTakenF"}, 32'(bus.pred_taken_f), 32'(expPredT));
        checkOutput({tag, ".predTargetF"}, bus.pred_target_f, expPredTgt);
        checkOutput({tag, ".mispredict"}, 32'(bus.mispredict_e), 32'(expMiss));
        checkOutput({tag, ".redirect"}, bus.redirect_pc_e, expRedir);

        @(posedge clk);
        if (!rst && validE) begin
            i   = idxOf(pcE);
            hit = modelHit(pcE);
            if (kind != KIND_NONE) mCtl++;
            if (kind == KIND_JAL || kind == KIND_JALR) begin
                mValid[i] = 1; mTag[i] = tagOf(pcE); mTarget[i] = act; mCtr[i] = 3;
            end else if (kind == KIND_BR) begin
                if (hit != 0) begin
                    if (taken) begin
                        mCtr[i]    = (mCtr[i] < 3) ? mCtr[i] + 1 : 3;
                        mTarget[i] = act;
                    end else begin
                        mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
                    end
                end else if (taken) begin
                    mValid[i] = 1; mTag[i] = tagOf(pcE); mTarget[i] = act; mCtr[i] = 2;
                end
            end else if (hit != 0) begin
                mValid[i] = 0;
            end
        end
        if (!rst && expMiss) mMiss++;
        @(negedge clk);
    endtask

    task automatic checkPrediction(input string tag, input logic [31:0] pcF);
        applyStimulus(tag, pcF, 1'b0, 32'h0, KIND_NONE, 3'b000, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] rPcE;
        logic [31:0] rPcF;
        logic        rPredT;
        logic [31:0] rPredTgt;
        int          rKind;

        pcPool  = '{32'h40, 32'h80, 32'h44, 32'h100, 32'h140, 32'h3C0, 32'h48, 32'h1040};
        tgtPool = '{32'h80, 32'h200, 32'h204, 32'h4C};
        modelReset();

        // Reset held two cycles with a jal presented; it must not be installed.
        @(negedge clk);
        applyStimulus("rstJal", 32'h300, 1'b1, 32'h300, KIND_JAL, 3'b000, 1'b0, 1'b0, 1'b0,
                      32'h500, 32'h0, 1'b0, 32'h0);
        applyStimulus("rstJal2", 32'h300, 1'b1, 32'h300, KIND_JAL, 3'b000, 1'b0, 1'b0, 1'b0,
                      32'h500, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        modelReset();

        checkPrediction("reset40", 32'h40);
        checkPrediction("reset300", 32'h300);
        for (int i = 0; i < 16; i++) checkPrediction("sweep", 32'h1000 + 32'(i * 4));
`ifdef BPRED_STATS_EN
        checkOutput("statCtlReset", statCtl, 32'd0);
        checkOutput("statMissReset", statMiss, 32'd0);
`endif

        // beq taken from a miss, looking up the same index in the same cycle (old value expected).
        applyStimulus("beqAlloc", 32'h40, 1'b1, 32'h40, KIND_BR, 3'b000, 1'b1, 1'b0, 1'b0,
                      32'h80, 32'h0, 1'b0, 32'h44);
        checkPrediction("beqAfter", 32'h40);

        applyStimulus("beqNt1", 32'h40, 1'b1, 32'h40, KIND_BR, 3'b000, 1'b0, 1'b0, 1'b0,
                      32'h80, 32'h0, 1'b1, 32'h80);
        applyStimulus("beqNt2", 32'h40, 1'b1, 32'h40, KIND_BR, 3'b000, 1'b0, 1'b0, 1'b0,
                      32'h80, 32'h0, 1'b0, 32'h44);
        applyStimulus("beqNt3", 32'h40, 1'b1, 32'h40, KIND_BR, 3'b000, 1'b0, 1'b0, 1'b0,
                      32'h80, 32'h0, 1'b0, 32'h44);
        checkPrediction("ctrFloor", 32'h40);
        for (int i = 0; i < 4; i++)
            applyStimulus("beqT", 32'h40, 1'b1, 32'h40, KIND_BR, 3'b000, 1'b1, 1'b0, 1'b0,
                          32'h80, 32'h0, 1'b0, 32'h44);
        applyStimulus("beqNtSat", 32'h40, 1'b1, 32'h40, KIND_BR, 3'b000, 1'b0, 1'b0, 1'b0,
                      32'h80, 32'h0, 1'b1, 32'h80);
        checkPrediction("ctrStillTaken", 32'h40);

        // Each condition type once, with flags chosen to make it taken.
        applyStimulus("bne", 32'h48, 1'b1, 32'h48, KIND_BR, 3'b001, 1'b0, 1'b0, 1'b0, 32'h90, 32'h0, 1'b0, 32'h0);
        applyStimulus("blt", 32'h4C, 1'b1, 32'h4C, KIND_BR, 3'b100, 1'b0, 1'b1, 1'b0, 32'h94, 32'h0, 1'b0, 32'h0);
        applyStimulus("bge", 32'h50, 1'b1, 32'h50, KIND_BR, 3'b101, 1'b0, 1'b0, 1'b1, 32'h98, 32'h0, 1'b0, 32'h0);
        applyStimulus("bltu", 32'h54, 1'b1, 32'h54, KIND_BR, 3'b110, 1'b0, 1'b0, 1'b1, 32'h9C, 32'h0, 1'b0, 32'h0);
        applyStimulus("bgeu", 32'h58, 1'b1, 32'h58, KIND_BR, 3'b111, 1'b0, 1'b1, 1'b0, 32'hA0, 32'h0, 1'b0, 32'h0);
        applyStimulus("brUndef", 32'h5C, 1'b1, 32'h5C, KIND_BR, 3'b010, 1'b1, 1'b1, 1'b1, 32'hA4, 32'h0, 1'b0, 32'h0);
        checkPrediction("undefNoAlloc", 32'h5C);

        applyStimulus("jalr", 32'h100, 1'b1, 32'h100, KIND_JALR, 3'b000, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h204, 1'b1, 32'h200);
        checkPrediction("jalrAfter", 32'h100);
        applyStimulus("jal", 32'h140, 1'b1, 32'h140, KIND_JAL, 3'b000, 1'b0, 1'b0, 1'b0,
                      32'h600, 32'h0, 1'b1, 32'h600);

        applyStimulus("aliasOther", 32'h40, 1'b1, 32'h80, KIND_NONE, 3'b000, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h0, 1'b1, 32'h80);
        applyStimulus("aliasHit", 32'h40, 1'b1, 32'h40, KIND_NONE, 3'b000, 1'b0, 1'b0, 1'b0,
                      32'h0, 32'h0, 1'b1, 32'h80);
        checkPrediction("aliasCleared", 32'h40);

        applyStimulus("bubble", 32'h180, 1'b0, 32'h180, KIND_JAL, 3'b000, 1'b1, 1'b1, 1'b1,
                      32'h700, 32'h700, 1'b0, 32'h0);
        checkPrediction("bubbleNoWrite", 32'h180);

        for (int n = 0; n < 300; n++) begin
            rPcE  = pcPool[$urandom_range(0, 7)];
            rPcF  = ($urandom_range(0, 1) == 0) ? rPcE : pcPool[$urandom_range(0, 7)];
            rKind = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) begin
                modelLookup(rPcE, rPredT, rPredTgt);
            end else begin
                rPredT   = 1'($urandom_range(0, 1));
                rPredTgt = tgtPool[$urandom_range(0, 3)];
            end
            applyStimulus("rand", rPcF, ($urandom_range(0, 7) != 0), rPcE, rKind,
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), tgtPool[$urandom_range(0, 3)],
                          tgtPool[$urandom_range(0, 3)], rPredT, rPredTgt);
        end

`ifdef BPRED_STATS_EN
        checkOutput("statCtl", statCtl, 32'(mCtl));
        checkOutput("statMiss", statMiss, 32'(mMiss));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
